// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - funct3 encodings of the supported loads and stores
//   - FSM state type
//   - is_legal(): decides whether an incoming access may reach memory
// -----------------------------------------------------------------------------
package lsu_pkg;

   // Load encodings
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store encodings
   localparam logic [2:0] F3_SD  = 3'b011;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SH  = 3'b001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // An access is legal when it is exactly one of load/store, uses a supported
   // funct3, is naturally aligned (so it never crosses a doubleword), and,
   // for stores, enables at least one byte.
   function automatic logic is_legal(input logic       load,
                                     input logic       store,
                                     input logic [2:0] funct3,
                                     input logic [7:0] wmask,
                                     input logic [2:0] off);
      logic ok;
      ok = 1'b0;
      if (load && !store) begin
         case (funct3)
            F3_LD:         ok = (off == 3'b000);
            F3_LW, F3_LWU: ok = (off[1:0] == 2'b00);
            F3_LH, F3_LHU: ok = (off[0] == 1'b0);
            default:       ok = 1'b0;
         endcase
      end else if (store && !load && (wmask != 8'h00)) begin
         case (funct3)
            F3_SD:   ok = (off == 3'b000);
            F3_SW:   ok = (off[1:0] == 2'b00);
            F3_SH:   ok = (off[0] == 1'b0);
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational lane select and sign/zero extension of a load result.
// Ports:
//   i_mem_rdata  raw doubleword returned by memory
//   i_off        byte offset of the access within the doubleword
//   i_funct3     load type (LD/LW/LWU/LH/LHU)
//   o_rdata      right-justified, extended load data
// -----------------------------------------------------------------------------
module load_extend
   import lsu_pkg::*;
(
   input  logic [63:0] i_mem_rdata,
   input  logic [2:0]  i_off,
   input  logic [2:0]  i_funct3,
   output logic [63:0] o_rdata
);

   logic [63:0] w_shifted;

   assign w_shifted = i_mem_rdata >> {i_off, 3'b000};

   always_comb begin
      // NOTE: default assignment first so every path drives o_rdata; no latch.
      o_rdata = w_shifted;
      case (i_funct3)
         F3_LW:   o_rdata = {{32{w_shifted[31]}}, w_shifted[31:0]};
         F3_LWU:  o_rdata = {32'h0, w_shifted[31:0]};
         F3_LH:   o_rdata = {{48{w_shifted[15]}}, w_shifted[15:0]};
         F3_LHU:  o_rdata = {48'h0, w_shifted[15:0]};
         default: ;  // LD: full doubleword, no extension
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Runs one memory-stage load or store against a 64-bit doubleword-addressed
// memory with a req/ready handshake, returning extended load data.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req_valid           memory-stage instruction present
//   i_load, i_store       decoder LoadData / StoreData
//   i_funct3              inst[14:12]
//   i_addr                effective byte address
//   i_wdata, i_wmask      right-justified store data and byte mask
//   o_busy                pipeline stall request
//   o_done, o_fault       one-cycle completion pulse, fault qualifier
//   o_rdata               extended load result (0 for stores/faults)
//   o_mem_*               memory request channel (aligned address, lanes)
//   i_mem_rdata           read doubleword
//   i_mem_ready           memory accepts/completes the request this cycle
// -----------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int TIMEOUT = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req_valid,
   input  logic              i_load,
   input  logic              i_store,
   input  logic [2:0]        i_funct3,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [63:0]       i_wdata,
   input  logic [7:0]        i_wmask,
   output logic              o_busy,
   output logic              o_done,
   output logic [63:0]       o_rdata,
   output logic              o_fault,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [63:0]       o_mem_wdata,
   output logic [7:0]        o_mem_be,
   input  logic [63:0]       i_mem_rdata,
   input  logic              i_mem_ready
);

   // Watchdog counter; one bit minimum keeps the design legal with TIMEOUT=0.
   localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic             WD_EN    = (TIMEOUT > 0);

   state_t              r_state;
   logic [2:0]          r_off;
   logic [2:0]          r_funct3;
   logic                r_load;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [63:0]         r_mem_wdata;
   logic [7:0]          r_mem_be;
   logic                r_done;
   logic                r_fault;
   logic [63:0]         r_rdata;

   logic                w_accept;
   logic                w_legal;
   logic                w_expire;
   logic [63:0]         w_wdata_sh;
   logic [7:0]          w_be_sh;
   logic [63:0]         w_ext_rdata;

   assign w_accept   = (r_state == IDLE) && i_req_valid && (i_load || i_store);
   assign w_legal    = is_legal(i_load, i_store, i_funct3, i_wmask, i_addr[2:0]);
   // This cycle's increment would bring the counter to TIMEOUT.
   assign w_expire   = WD_EN && (r_cnt == CNT_LAST);
   assign w_wdata_sh = i_wdata << {i_addr[2:0], 3'b000};
   assign w_be_sh    = i_store ? (i_wmask << i_addr[2:0]) : 8'h00;

   load_extend u_load_extend (
      .i_mem_rdata (i_mem_rdata),
      .i_off       (r_off),
      .i_funct3    (r_funct3),
      .o_rdata     (w_ext_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_off       <= 3'b000;
         r_funct3    <= 3'b000;
         r_load      <= 1'b0;
         r_cnt       <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 64'h0;
         r_mem_be    <= 8'h00;
         r_done      <= 1'b0;
         r_fault     <= 1'b0;
         r_rdata     <= 64'h0;
      end else begin
         // NOTE: non-blocking assignments throughout so every register samples
         // pre-edge values, independent of statement order.
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_off    <= i_addr[2:0];
                  r_funct3 <= i_funct3;
                  r_load   <= i_load;
                  r_rdata  <= 64'h0;
                  if (w_legal) begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= i_store;
                     r_mem_addr  <= {i_addr[ADDR_W-1:3], 3'b000};
                     r_mem_be    <= w_be_sh;
                     r_mem_wdata <= w_wdata_sh;
                     r_cnt       <= '0;
                     r_fault     <= 1'b0;
                     r_state     <= WAIT;
                  end else begin
                     // Rejected access: no memory traffic, fault next cycle.
                     r_fault <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= RESP;
                  end
               end
            end

            WAIT: begin
               if (i_mem_ready) begin
                  // Ready wins over a simultaneous watchdog expiry.
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_mem_be  <= 8'h00;
                  r_rdata   <= r_load ? w_ext_rdata : 64'h0;
                  r_done    <= 1'b1;
                  r_state   <= RESP;
               end else begin
                  if (r_cnt != CNT_MAX) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
                  if (w_expire) begin
                     r_mem_req <= 1'b0;
                     r_mem_we  <= 1'b0;
                     r_mem_be  <= 8'h00;
                     r_fault   <= 1'b1;
                     r_done    <= 1'b1;
                     r_state   <= RESP;
                  end
               end
            end

            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy      = (r_state != IDLE) || w_accept;
   assign o_done      = r_done;
   assign o_fault     = r_fault;
   assign o_rdata     = r_rdata;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_be    = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench: each issued access pushes its expected response (and, for
// legal accesses, its expected memory request) into queues; independent
// monitor processes pop and compare when the DUT shows done or mem_req.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   localparam int ADDR_W  = 64;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              rst_n;
   logic              i_req_valid;
   logic              i_load;
   logic              i_store;
   logic [2:0]        i_funct3;
   logic [ADDR_W-1:0] i_addr;
   logic [63:0]       i_wdata;
   logic [7:0]        i_wmask;
   logic              o_busy;
   logic              o_done;
   logic [63:0]       o_rdata;
   logic              o_fault;
   logic              o_mem_req;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [63:0]       o_mem_wdata;
   logic [7:0]        o_mem_be;
   logic [63:0]       i_mem_rdata;
   logic              i_mem_ready;

   load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req_valid (i_req_valid),
      .i_load      (i_load),
      .i_store     (i_store),
      .i_funct3    (i_funct3),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .i_wmask     (i_wmask),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_rdata     (o_rdata),
      .o_fault     (o_fault),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .o_mem_be    (o_mem_be),
      .i_mem_rdata (i_mem_rdata),
      .i_mem_ready (i_mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [63:0] rdata;
      logic        fault;
      int          acc_cyc;
      int          lat;
   } sb_item_t;

   typedef struct {
      string       name;
      logic [63:0] addr;
      logic        we;
      logic [7:0]  be;
      logic [63:0] wdata;
      int          reqc;
   } mem_item_t;

   sb_item_t    sb_q[$];
   mem_item_t   mem_q[$];
   sb_item_t    sb_cur;
   mem_item_t   mem_cur;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          ready_at = -1;       // WAIT-cycle index at which memory answers; -1 never
   logic [63:0] mem_data = 64'h0;
   int          req_cnt = 0;

   localparam logic [63:0] D = 64'h8877665544332211;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor
   always @(negedge clk) begin
      if (rst_n && o_done) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 required no pending response");
         end else begin
            sb_cur = sb_q.pop_front();
            check({sb_cur.name, "_rdata"}, o_rdata, sb_cur.rdata);
            check({sb_cur.name, "_fault"}, 64'(o_fault), 64'(sb_cur.fault));
            check({sb_cur.name, "_latency"}, 64'(cyc - sb_cur.acc_cyc), 64'(sb_cur.lat));
         end
      end
   end

   // Memory model and request monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         req_cnt     = 0;
         i_mem_ready = 1'b0;
         i_mem_rdata = 64'h0;
      end else if (o_mem_req) begin
         if (req_cnt == 0) begin
            if (mem_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_mem_req: got mem_req=1 required 0");
               mem_cur = '{name: "none", addr: o_mem_addr, we: o_mem_we, be: o_mem_be,
                           wdata: o_mem_wdata, reqc: 0};
            end else begin
               mem_cur = mem_q.pop_front();
            end
         end
         req_cnt++;
         check({mem_cur.name, "_mem_addr"},  o_mem_addr,       mem_cur.addr);
         check({mem_cur.name, "_mem_we"},    64'(o_mem_we),    64'(mem_cur.we));
         check({mem_cur.name, "_mem_be"},    64'(o_mem_be),    64'(mem_cur.be));
         check({mem_cur.name, "_mem_wdata"}, o_mem_wdata,      mem_cur.wdata);
         i_mem_ready = (ready_at >= 0) && (req_cnt - 1 == ready_at);
         i_mem_rdata = mem_data;
      end else begin
         if (req_cnt > 0) begin
            check({mem_cur.name, "_req_cycles"}, 64'(req_cnt), 64'(mem_cur.reqc));
         end
         req_cnt     = 0;
         i_mem_ready = 1'b0;
      end
   end

   // Issue one access at a negedge and wait (bounded) until the unit is idle.
   task automatic issue(input string nm, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input logic [7:0] wm,
                        input int rdy, input bit legal, input logic [63:0] exp_rd,
                        input bit exp_f, input int exp_lat, input logic [7:0] exp_be,
                        input logic [63:0] exp_wd, input int exp_reqc);
      ready_at = rdy;
      mem_data = D;
      sb_q.push_back('{name: nm, rdata: exp_rd, fault: exp_f, acc_cyc: cyc, lat: exp_lat});
      if (legal) begin
         mem_q.push_back('{name: nm, addr: a & ~64'h7, we: st, be: exp_be,
                           wdata: exp_wd, reqc: exp_reqc});
      end
      i_req_valid = 1'b1;
      i_load      = ld;
      i_store     = st;
      i_funct3    = f3;
      i_addr      = a;
      i_wdata     = wd;
      i_wmask     = wm;
      #1;
      check({nm, "_busy_on_accept"}, 64'(o_busy), 64'd1);
      @(negedge clk);
      i_req_valid = 1'b0;
      i_load      = 1'b0;
      i_store     = 1'b0;
      for (int i = 0; i < 100 && o_busy; i++) @(negedge clk);
      check({nm, "_idle_reached"}, 64'(o_busy), 64'd0);
      // Result must persist after the done pulse.
      check({nm, "_rdata_hold"}, o_rdata, exp_rd);
      check({nm, "_fault_hold"}, 64'(o_fault), 64'(exp_f));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      rst_n       = 1'b0;
      i_req_valid = 1'b0;
      i_load      = 1'b0;
      i_store     = 1'b0;
      i_funct3    = 3'b000;
      i_addr      = '0;
      i_wdata     = 64'h0;
      i_wmask     = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_busy",      64'(o_busy),    64'd0);
      check("rst_done",      64'(o_done),    64'd0);
      check("rst_fault",     64'(o_fault),   64'd0);
      check("rst_rdata",     o_rdata,        64'd0);
      check("rst_mem_req",   64'(o_mem_req), 64'd0);
      check("rst_mem_we",    64'(o_mem_we),  64'd0);
      check("rst_mem_addr",  o_mem_addr,     64'd0);
      check("rst_mem_be",    64'(o_mem_be),  64'd0);
      check("rst_mem_wdata", o_mem_wdata,    64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      //     name    ld st  f3      addr          wdata                 wm     rdy lg exp_rdata               f  lat be     exp_wdata              reqc
      issue("ld",    1, 0, 3'b011, 64'h1000, 64'h0,                 8'h00,  3, 1, D,                     0, 5, 8'h00, 64'h0,                 4);
      issue("lw",    1, 0, 3'b010, 64'h1004, 64'h0,                 8'h00,  0, 1, 64'hFFFFFFFF88776655, 0, 2, 8'h00, 64'h0,                 1);
      issue("lwu",   1, 0, 3'b110, 64'h1004, 64'h0,                 8'h00,  0, 1, 64'h0000000088776655, 0, 2, 8'h00, 64'h0,                 1);
      issue("lh",    1, 0, 3'b001, 64'h1006, 64'h0,                 8'h00,  0, 1, 64'hFFFFFFFFFFFF8877, 0, 2, 8'h00, 64'h0,                 1);
      issue("lhu",   1, 0, 3'b101, 64'h1006, 64'h0,                 8'h00,  0, 1, 64'h0000000000008877, 0, 2, 8'h00, 64'h0,                 1);
      issue("ld_f3", 1, 0, 3'b000, 64'h1000, 64'h0,                 8'h00,  0, 0, 64'h0,                1, 1, 8'h00, 64'h0,                 0);
      issue("sh",    0, 1, 3'b001, 64'h2002, 64'hBEEF,              8'h03,  0, 1, 64'h0,                0, 2, 8'h0C, 64'h00000000BEEF0000, 1);
      issue("sw_mis",0, 1, 3'b010, 64'h2002, 64'hBEEF,              8'h0F,  0, 0, 64'h0,                1, 1, 8'h00, 64'h0,                 0);
      issue("ld_st", 1, 1, 3'b011, 64'h1000, 64'h0,                 8'hFF,  0, 0, 64'h0,                1, 1, 8'h00, 64'h0,                 0);
      issue("sd_m0", 0, 1, 3'b011, 64'h3000, 64'h1234,              8'h00,  0, 0, 64'h0,                1, 1, 8'h00, 64'h0,                 0);
      issue("lw_mis",1, 0, 3'b010, 64'h1002, 64'h0,                 8'h00,  0, 0, 64'h0,                1, 1, 8'h00, 64'h0,                 0);
      issue("sd",    0, 1, 3'b011, 64'h3000, 64'h0123456789ABCDEF,  8'hFF,  1, 1, 64'h0,                0, 3, 8'hFF, 64'h0123456789ABCDEF, 2);
      issue("sw_hi", 0, 1, 3'b010, 64'h3004, 64'hCAFEF00D,          8'h0F,  2, 1, 64'h0,                0, 4, 8'hF0, 64'hCAFEF00D00000000, 3);
      issue("tmo",   1, 0, 3'b011, 64'h1000, 64'h0,                 8'h00, -1, 1, 64'h0,                1, 17, 8'h00, 64'h0,                16);
      issue("rdy16", 1, 0, 3'b011, 64'h1000, 64'h0,                 8'h00, 15, 1, D,                    0, 17, 8'h00, 64'h0,                16);

      // Reset during WAIT: request drops at once and no done follows.
      ready_at = -1;
      mem_q.push_back('{name: "rst_ld", addr: 64'h1000, we: 1'b0, be: 8'h00,
                        wdata: 64'h0, reqc: 0});
      i_req_valid = 1'b1;
      i_load      = 1'b1;
      i_funct3    = 3'b011;
      i_addr      = 64'h1000;
      @(negedge clk);
      i_req_valid = 1'b0;
      i_load      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wait_mem_req_before", 64'(o_mem_req), 64'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_wait_mem_req", 64'(o_mem_req), 64'd0);
      check("rst_wait_busy",    64'(o_busy),    64'd0);
      check("rst_wait_done",    64'(o_done),    64'd0);
      mem_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_wait_no_done", 64'(o_done), 64'd0);
      issue("ld_post_rst", 1, 0, 3'b011, 64'h1000, 64'h0, 8'h00, 0, 1, D, 0, 2, 8'h00, 64'h0, 1);

      repeat (3) @(negedge clk);
      check("sb_drained",  64'(sb_q.size()),  64'd0);
      check("mem_drained", 64'(mem_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
